// File: rtl/fifo_writer_gen.sv
// fifo_writer_gen: drives the write side of a FIFO with one block of words
// per start/done handshake. Writes are throttled by a pseudo-random
// go signal, so the FIFO sees both bursts and gaps.
//
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   start_i          start request (only honoured in IDLE)
//   length_i         words in block (0 goes straight to DONE)
//   rate_i           throttle threshold, 255 = no throttling
//   pattern_i        0 = incrementing data, 1 = walking rotate-left
//   seed_i           first data word of the block
//   dout, wren       FIFO write data (registered) and write enable
//   full             FIFO full, blocks wren in the same cycle
//   busy_o           high while the block is being written
//   done_o           one-cycle pulse after the final accepted write
//   count_o          words accepted in the current or last block
module fifo_writer_gen #(
  parameter int          WIDTH      = 16,
  parameter int          LEN_WIDTH  = 10,
  parameter int          RATE_WIDTH = 8,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [LEN_WIDTH-1:0]  length_i,
  input  logic [RATE_WIDTH-1:0] rate_i,
  input  logic                  pattern_i,
  input  logic [WIDTH-1:0]      seed_i,
  output logic [WIDTH-1:0]      dout,
  output logic                  wren,
  input  logic                  full,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [LEN_WIDTH-1:0]  count_o
);

  // An all-zero LFSR would lock up, so a zero seed is replaced.
  localparam logic [15:0] SEED_EFF = (LFSR_SEED == 16'h0000) ? 16'hACE1 : LFSR_SEED;
  localparam logic [LEN_WIDTH-1:0] ONE_LEN = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0]     ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t               state_reg, state_next;
  logic [WIDTH-1:0]     dout_reg, dout_next;
  logic [LEN_WIDTH-1:0] count_reg, count_next;
  logic [LEN_WIDTH-1:0] len_reg, len_next;
  logic                 pat_reg, pat_next;
  logic [15:0]          lfsr_reg;
  logic                 go_reg;
  logic                 wren_int;
  logic [WIDTH-1:0]     rot_word;

  // Walking pattern: rotate left by one, MSB wraps to bit 0.
  genvar gi;
  generate
    for (gi = 1; gi < WIDTH; gi++) begin : g_rot
      assign rot_word[gi] = dout_reg[gi-1];
    end
  endgenerate
  assign rot_word[0] = dout_reg[WIDTH-1];

  // Combinational enable gives zero-cycle response to full.
  assign wren_int = (state_reg == ST_WRITE) && go_reg && !full;

  // Throttle: Fibonacci LFSR x^16+x^14+x^13+x^11+1, go registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_reg <= SEED_EFF;
      go_reg   <= 1'b0;
    end else begin
      lfsr_reg <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
      go_reg   <= (lfsr_reg[RATE_WIDTH-1:0] <= rate_i);
    end
  end

  always_comb begin
    state_next = state_reg;
    dout_next  = dout_reg;
    count_next = count_reg;
    len_next   = len_reg;
    pat_next   = pat_reg;
    case (state_reg)
      ST_IDLE: begin
        if (start_i) begin
          len_next   = length_i;
          pat_next   = pattern_i;
          count_next = '0;
          // A zero word never changes under rotation, so start at 1.
          dout_next  = (pattern_i && (seed_i == '0)) ? ONE_W : seed_i;
          state_next = (length_i != '0) ? ST_WRITE : ST_DONE;
        end
      end
      ST_WRITE: begin
        if (wren_int) begin
          count_next = count_reg + ONE_LEN;
          dout_next  = pat_reg ? rot_word : (dout_reg + ONE_W);
          if ((count_reg + ONE_LEN) == len_reg) begin
            state_next = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      dout_reg  <= '0;
      count_reg <= '0;
      len_reg   <= '0;
      pat_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      dout_reg  <= dout_next;
      count_reg <= count_next;
      len_reg   <= len_next;
      pat_reg   <= pat_next;
    end
  end

  assign dout    = dout_reg;
  assign wren    = wren_int;
  assign count_o = count_reg;
  assign busy_o  = (state_reg == ST_WRITE);
  // State is a register, so done_o is a registered one-cycle pulse.
  assign done_o  = (state_reg == ST_DONE);

endmodule

// File: tb/tb_fifo_writer_gen.sv
module tb_fifo_writer_gen;

  localparam int W  = 16;
  localparam int LW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic [LW-1:0] length_i;
  logic [7:0]    rate_i;
  logic          pattern_i;
  logic [W-1:0]  seed_i;
  logic [W-1:0]  dout;
  logic          wren;
  logic          full;
  logic          busy_o;
  logic          done_o;
  logic [LW-1:0] count_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_writer_gen #(.WIDTH(W), .LEN_WIDTH(LW), .RATE_WIDTH(8), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .length_i(length_i), .rate_i(rate_i),
    .pattern_i(pattern_i), .seed_i(seed_i), .dout(dout), .wren(wren), .full(full),
    .busy_o(busy_o), .done_o(done_o), .count_o(count_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Next word of the block, straight from the pattern definitions.
  function automatic logic [15:0] next_word(input logic [15:0] w, input bit p);
    logic [16:0] t;
    if (p) begin
      t = {1'b0, w} * 2;
      return t[15:0] | {15'd0, t[16]};
    end
    return w + 16'd1;
  endfunction

  // full_mode: 0 never full, 1 full in block cycles 2..4, 2 random full.
  task automatic run_block(input int len, input logic [15:0] seed, input bit pat,
                           input logic [7:0] rate, input int full_mode, input bit restart,
                           output logic [15:0] first_w, output logic [15:0] last_w);
    logic [15:0] q[$];
    logic [15:0] w;
    int written, cyc, last_cyc;
    bit done_seen;
    w = (pat && seed == 16'd0) ? 16'd1 : seed;
    for (int i = 0; i < len; i++) begin
      q.push_back(w);
      w = next_word(w, pat);
    end
    first_w = 16'hxxxx;
    last_w  = 16'hxxxx;
    @(negedge clk);
    start_i = 1'b1; length_i = LW'(len); seed_i = seed; pattern_i = pat; rate_i = rate; full = 1'b0;
    #2;
    check("start_cycle_wren", {31'd0, wren}, 32'd0);
    written = 0; cyc = 0; last_cyc = 0; done_seen = 0;
    while (!done_seen && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      start_i  = restart && (cyc == 3);
      length_i = restart ? LW'(2) : LW'(len);
      case (full_mode)
        1:       full = (cyc >= 2 && cyc <= 4);
        2:       full = ($urandom_range(0, 3) == 0);
        default: full = 1'b0;
      endcase
      #2;
      if (cyc == 1) check("busy_after_start", {31'd0, busy_o}, {31'd0, len != 0});
      check("wren_while_full", {31'd0, wren && full}, 32'd0);
      if (rate == 8'd255)
        check("wren_exact", {31'd0, wren}, {31'd0, (written < len) && !full});
      if (wren) begin
        if (q.size() == 0) begin
          check("extra_write", 32'd1, 32'd0);
        end else begin
          check("dout_word", {16'd0, dout}, {16'd0, q[0]});
          check("count_running", {22'd0, count_o}, written);
          if (written == 0) first_w = dout;
          last_w = dout;
          void'(q.pop_front());
        end
        written++;
        last_cyc = cyc;
      end else if (busy_o && q.size() > 0) begin
        check("dout_hold", {16'd0, dout}, {16'd0, q[0]});
      end
      if (done_o) begin
        done_seen = 1;
        check("done_timing", cyc, (len == 0) ? 1 : last_cyc + 1);
        check("write_total", written, len);
        check("count_final", {22'd0, count_o}, len);
      end
    end
    if (!done_seen) check("done_timeout", 32'd0, 32'd1);
    start_i = 1'b0;
    @(negedge clk);
    full = 1'b0;
    #2;
    check("done_one_cycle", {31'd0, done_o}, 32'd0);
    check("busy_after_done", {31'd0, busy_o}, 32'd0);
    check("count_hold", {22'd0, count_o}, len);
    if (rate == 8'd128 && len >= 16) check("duty_below_full", {31'd0, cyc > len + 1}, 32'd1);
    $display("block len=%0d seed=%04h pat=%0d rate=%0d full_mode=%0d writes=%0d cycles=%0d",
             len, seed, pat, rate, full_mode, written, cyc);
  endtask

  typedef struct {
    int          len;
    logic [15:0] seed;
    bit          pat;
    logic [15:0] first;
    logic [15:0] last;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [15:0] fw, lw;
    vecs[0] = '{4, 16'h0010, 1'b0, 16'h0010, 16'h0013};
    vecs[1] = '{3, 16'hFFFE, 1'b0, 16'hFFFE, 16'h0000};
    vecs[2] = '{3, 16'h4000, 1'b1, 16'h4000, 16'h0001};
    vecs[3] = '{2, 16'h0000, 1'b1, 16'h0001, 16'h0002};
    vecs[4] = '{1, 16'h8000, 1'b1, 16'h8000, 16'h8000};
    vecs[5] = '{5, 16'h00FF, 1'b0, 16'h00FF, 16'h0103};

    rst = 1'b1; start_i = 1'b0; length_i = '0; rate_i = 8'd255; pattern_i = 1'b0;
    seed_i = '0; full = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check("rst_dout", {16'd0, dout}, 32'd0);
    check("rst_wren", {31'd0, wren}, 32'd0);
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_done", {31'd0, done_o}, 32'd0);
    check("rst_count", {22'd0, count_o}, 32'd0);
    rst = 1'b0;

    // Table-driven blocks at full rate, no backpressure.
    for (int i = 0; i < 6; i++) begin
      run_block(vecs[i].len, vecs[i].seed, vecs[i].pat, 8'd255, 0, 1'b0, fw, lw);
      check("table_first", {16'd0, fw}, {16'd0, vecs[i].first});
      check("table_last", {16'd0, lw}, {16'd0, vecs[i].last});
    end

    // Backpressure in block cycles 2..4.
    run_block(4, 16'h0010, 1'b0, 8'd255, 1, 1'b0, fw, lw);
    check("bp_last", {16'd0, lw}, 32'h0013);
    // Zero-length block, then a block with an ignored second start.
    run_block(0, 16'h1234, 1'b0, 8'd255, 0, 1'b0, fw, lw);
    run_block(8, 16'h0200, 1'b0, 8'd128, 0, 1'b1, fw, lw);
    check("restart_last", {16'd0, lw}, 32'h0207);
    // Throttled block with random backpressure.
    run_block(16, 16'h0001, 1'b1, 8'd128, 2, 1'b0, fw, lw);

    // Reset in the middle of a block.
    @(negedge clk);
    start_i = 1'b1; length_i = LW'(16); seed_i = 16'h0500; pattern_i = 1'b0; rate_i = 8'd128;
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #2;
    check("midrst_dout", {16'd0, dout}, 32'd0);
    check("midrst_wren", {31'd0, wren}, 32'd0);
    check("midrst_busy", {31'd0, busy_o}, 32'd0);
    check("midrst_count", {22'd0, count_o}, 32'd0);
    check("midrst_done", {31'd0, done_o}, 32'd0);
    @(negedge clk);
    #2;
    check("midrst_done_hold", {31'd0, done_o}, 32'd0);
    rst = 1'b0;
    $display("reset mid-block applied");
    run_block(2, 16'h0100, 1'b0, 8'd255, 0, 1'b0, fw, lw);
    check("post_rst_last", {16'd0, lw}, 32'h0101);

    // Randomized blocks.
    for (int i = 0; i < 8; i++) begin
      int          rl;
      logic [15:0] rs;
      bit          rp;
      logic [7:0]  rr;
      rl = $urandom_range(0, 20);
      rs = 16'($urandom);
      rp = 1'($urandom_range(0, 1));
      rr = (i % 3 == 0) ? 8'd255 : 8'($urandom_range(16, 255));
      run_block(rl, rs, rp, rr, 2, 1'b0, fw, lw);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
